// File: rtl/systolic_controller.sv
// Sequencer for an NxN systolic array: fetches operands, skews them onto the array edges, captures results, streams rows out.
// Optional feature: define SYSCTRL_PERF_EN to add the saturating busy-cycle counter on perf_cycles.
module systolic_controller #(
    parameter int N     = 4,
    parameter int WIDTH = 16,
    parameter int KMAX  = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [$clog2(KMAX+1)-1:0]   k_len,
    output logic                        busy,
    output logic                        err,
    output logic                        done,
    output logic                        mem_rd,
    output logic [$clog2(KMAX)-1:0]     mem_addr,
    input  logic [N*WIDTH-1:0]          mem_a_col,
    input  logic [N*WIDTH-1:0]          mem_b_row,
    output logic                        arr_ena,
    output logic [N*WIDTH-1:0]          arr_a_west,
    output logic [N*WIDTH-1:0]          arr_b_north,
    input  logic [N*N*WIDTH-1:0]        arr_z,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [$clog2(N)-1:0]        res_row,
    output logic [N*WIDTH-1:0]          res_data
`ifdef SYSCTRL_PERF_EN
    ,
    output logic [15:0]                 perf_cycles
`endif
);

    // state   | meaning
    // IDLE    | waiting for a legal start
    // FETCH   | K operand reads, one A column and one B row per cycle
    // DRAIN   | 2N cycles of zeros while in-flight operands finish
    // CAPTURE | register arr_z into the result buffer, enable still high
    // OUTPUT  | stream buffer rows under valid/ready
    // DONE    | one-cycle done pulse, then back to IDLE
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DRAIN   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_OUTPUT  = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam int KW = $clog2(KMAX+1);
    localparam int AW = $clog2(KMAX);
    localparam int RW = $clog2(N);
    localparam int CW = $clog2(KMAX + 2*N);

    logic [2:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [RW-1:0]       row_q, row_d;
    logic                rd_q, rd_d;
    logic                ena_q, ena_d;
    logic                err_q, err_d;
    logic [N*WIDTH-1:0]  buf_q [N];
    logic [N*WIDTH-1:0]  buf_d [N];
    logic                k_ok;

    always_comb begin
        k_ok    = (k_len != '0) && (k_len <= KW'(KMAX));
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        row_d   = row_q;
        buf_d   = buf_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                addr_d = '0;
                row_d  = '0;
                if (start) begin
                    if (k_ok) begin
                        state_d = S_FETCH;
                        cnt_d   = CW'(k_len - 1'b1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                addr_d = addr_q + 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DRAIN;
                    cnt_d   = CW'(2*N - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) state_d = S_CAPTURE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_CAPTURE: begin
                for (int r = 0; r < N; r++) buf_d[r] = arr_z[r*N*WIDTH +: N*WIDTH];
                state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (res_ready) begin
                    if (row_q == RW'(N-1)) state_d = S_DONE;
                    else                   row_d   = row_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Enable rises the cycle the first operand reaches the edge and falls right after capture.
    always_comb begin
        rd_d  = (state_q == S_FETCH);
        ena_d = (ena_q | rd_q) & (state_q != S_CAPTURE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            row_q   <= '0;
            rd_q    <= 1'b0;
            ena_q   <= 1'b0;
            err_q   <= 1'b0;
            buf_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            row_q   <= row_d;
            rd_q    <= rd_d;
            ena_q   <= ena_d;
            err_q   <= err_d;
            buf_q   <= buf_d;
        end
    end

    // Row/column i sees i extra delay stages; slots without a returned operand load zero.
    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [WIDTH-1:0] a_q [0:i];
        logic [WIDTH-1:0] a_d [0:i];
        logic [WIDTH-1:0] b_q [0:i];
        logic [WIDTH-1:0] b_d [0:i];

        always_comb begin
            a_d[0] = rd_q ? mem_a_col[i*WIDTH +: WIDTH] : '0;
            b_d[0] = rd_q ? mem_b_row[i*WIDTH +: WIDTH] : '0;
            for (int s = 1; s <= i; s++) begin
                a_d[s] = a_q[s-1];
                b_d[s] = b_q[s-1];
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                a_q <= '{default: '0};
                b_q <= '{default: '0};
            end else begin
                a_q <= a_d;
                b_q <= b_d;
            end
        end

        assign arr_a_west[i*WIDTH +: WIDTH]  = a_q[i];
        assign arr_b_north[i*WIDTH +: WIDTH] = b_q[i];
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign mem_rd    = (state_q == S_FETCH);
    assign mem_addr  = mem_rd ? addr_q : '0;
    assign arr_ena   = ena_q;
    assign res_valid = (state_q == S_OUTPUT);
    assign res_row   = res_valid ? row_q : '0;
    assign res_data  = res_valid ? buf_q[row_q] : '0;

`ifdef SYSCTRL_PERF_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if ((state_q == S_IDLE) && start && k_ok)  perf_d = '0;
        else if (busy && (perf_q != 16'hFFFF))     perf_d = perf_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) perf_q <= '0;
        else       perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_systolic_controller.sv
// Randomized bench for systolic_controller with behavioural operand memory, accumulator array and matrix-product reference.
module tb_systolic_controller;
    localparam int N     = 4;
    localparam int WIDTH = 16;
    localparam int KMAX  = 16;
    localparam int KW    = $clog2(KMAX+1);
    localparam int AW    = $clog2(KMAX);
    localparam int RW    = $clog2(N);

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic                   start = 1'b0;
    logic [KW-1:0]          k_len = '0;
    logic                   busy, err, done, mem_rd, arr_ena, res_valid;
    logic [AW-1:0]          mem_addr;
    logic [N*WIDTH-1:0]     mem_a_col, mem_b_row, arr_a_west, arr_b_north, res_data;
    logic [N*N*WIDTH-1:0]   arr_z;
    logic                   res_ready = 1'b1;
    logic [RW-1:0]          res_row;
`ifdef SYSCTRL_PERF_EN
    logic [15:0]            perf_cycles;
`endif

    int checks = 0;
    int failures = 0;

    systolic_controller #(.N(N), .WIDTH(WIDTH), .KMAX(KMAX)) dut (
        .clock(clock), .reset(reset), .start(start), .k_len(k_len),
        .busy(busy), .err(err), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_a_col(mem_a_col), .mem_b_row(mem_b_row), .arr_ena(arr_ena),
        .arr_a_west(arr_a_west), .arr_b_north(arr_b_north), .arr_z(arr_z),
        .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row), .res_data(res_data)
`ifdef SYSCTRL_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    always #5 clock = ~clock;

    // Operand matrices: A[i][k] and B[k][j]
    logic [WIDTH-1:0] a_mat [N][KMAX];
    logic [WIDTH-1:0] b_mat [KMAX][N];

    // Operand memory: one-cycle read latency, garbage when not reading
    always @(posedge clock) begin
        if (mem_rd) begin
            for (int i = 0; i < N; i++) begin
                mem_a_col[i*WIDTH +: WIDTH] <= a_mat[i][mem_addr];
                mem_b_row[i*WIDTH +: WIDTH] <= b_mat[mem_addr][i];
            end
        end else begin
            mem_a_col <= {$urandom, $urandom};
            mem_b_row <= {$urandom, $urandom};
        end
    end

    // Accumulator cell array: a flows east, b flows south, ena=0 clears the accumulator
    logic [WIDTH-1:0] acc [N][N];
    logic [WIDTH-1:0] a_pipe [N][N];
    logic [WIDTH-1:0] b_pipe [N][N];
    logic [WIDTH-1:0] ain [N][N];
    logic [WIDTH-1:0] bin [N][N];

    always @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 0) ain[i][j] = arr_a_west[i*WIDTH +: WIDTH];
                else        ain[i][j] = a_pipe[i][j-1];
                if (i == 0) bin[i][j] = arr_b_north[j*WIDTH +: WIDTH];
                else        bin[i][j] = b_pipe[i-1][j];
                a_pipe[i][j] <= ain[i][j];
                b_pipe[i][j] <= bin[i][j];
                acc[i][j]    <= arr_ena ? (acc[i][j] + ain[i][j] * bin[i][j]) : '0;
            end
        end
    end

    always_comb begin
        arr_z = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                arr_z[(i*N+j)*WIDTH +: WIDTH] = acc[i][j];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_west(int i, int t, int kk);
        int k = t - 3 - i;
        if (k >= 0 && k < kk) return a_mat[i][k];
        return '0;
    endfunction

    function automatic logic [WIDTH-1:0] exp_north(int j, int t, int kk);
        int k = t - 3 - j;
        if (k >= 0 && k < kk) return b_mat[k][j];
        return '0;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < KMAX; k++) begin
                a_mat[i][k] = WIDTH'($urandom);
                b_mat[k][i] = WIDTH'($urandom);
            end
    endtask

    // stall_mode: 0 ready always, 1 three stall cycles on row 1, 2 random ready
    task automatic run_job(input int kk, input int stall_mode, input bit poke_start, input string name);
        logic [WIDTH-1:0]   c_ref [N][N];
        int                 t, done_t, first_v, stalls, stall_left, rows_seen;
        int                 bad_rd, bad_ena, bad_busy, bad_edge, bad_hold, bad_rows, n_err, bad_idle;
        bit                 prev_stall;
        logic [RW-1:0]      prev_row;
        logic [N*WIDTH-1:0] prev_data;

        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int s = 0;
                for (int k = 0; k < kk; k++) s = s + a_mat[i][k] * b_mat[k][j];
                c_ref[i][j] = s[WIDTH-1:0];
            end

        t = 0; done_t = -1; first_v = -1; stalls = 0; rows_seen = 0;
        bad_rd = 0; bad_ena = 0; bad_busy = 0; bad_edge = 0; bad_hold = 0; bad_rows = 0; n_err = 0; bad_idle = 0;
        prev_stall = 1'b0; prev_row = '0; prev_data = '0;
        stall_left = (stall_mode == 1) ? 3 : 0;

        @(negedge clock);
        start = 1'b1;
        k_len = KW'(kk);
        while (done_t < 0 && t < kk + 3*N + 80) begin
            @(negedge clock);
            t++;
            start = poke_start && (t == kk + 2*N + 3);
            if (res_valid) begin
                if (stall_mode == 1) begin
                    if (res_row == RW'(1) && stall_left > 0) begin
                        res_ready = 1'b0;
                        stall_left--;
                    end else res_ready = 1'b1;
                end else if (stall_mode == 2) res_ready = ($urandom_range(0, 2) != 0);
                else res_ready = 1'b1;
            end else res_ready = 1'b1;

            if (mem_rd !== (t <= kk)) bad_rd++;
            if (mem_rd && mem_addr !== AW'(t - 1)) bad_rd++;
            if (arr_ena !== (t >= 3 && t <= kk + 2*N + 1)) bad_ena++;
            if (busy !== 1'b1) bad_busy++;
            if (err) n_err++;
            for (int i = 0; i < N; i++) begin
                if (arr_a_west[i*WIDTH +: WIDTH] !== exp_west(i, t, kk)) bad_edge++;
                if (arr_b_north[i*WIDTH +: WIDTH] !== exp_north(i, t, kk)) bad_edge++;
            end
            if (res_valid) begin
                if (first_v < 0) first_v = t;
                if (prev_stall && (res_row !== prev_row || res_data !== prev_data)) bad_hold++;
                if (res_ready) begin
                    if (rows_seen >= N || res_row !== RW'(rows_seen)) bad_rows++;
                    else
                        for (int j = 0; j < N; j++)
                            if (res_data[j*WIDTH +: WIDTH] !== c_ref[rows_seen][j]) bad_rows++;
                    rows_seen++;
                end else stalls++;
                prev_stall = !res_ready;
                prev_row   = res_row;
                prev_data  = res_data;
            end else begin
                if (prev_stall) bad_hold++;
                prev_stall = 1'b0;
            end
            if (done) done_t = t;
        end
        start = 1'b0;
        res_ready = 1'b1;

        check($sformatf("%s.done_seen", name), done_t >= 0, 1);
        check($sformatf("%s.done_cycle", name), done_t, kk + 3*N + 2 + stalls);
        check($sformatf("%s.first_valid", name), first_v, kk + 2*N + 2);
        check($sformatf("%s.rows", name), rows_seen, N);
        check($sformatf("%s.row_data", name), bad_rows, 0);
        check($sformatf("%s.fetch", name), bad_rd, 0);
        check($sformatf("%s.ena_window", name), bad_ena, 0);
        check($sformatf("%s.busy", name), bad_busy, 0);
        check($sformatf("%s.edge_skew", name), bad_edge, 0);
        check($sformatf("%s.stall_hold", name), bad_hold, 0);
        check($sformatf("%s.no_err", name), n_err, 0);
        if (stall_mode == 1) check($sformatf("%s.stall_cycles", name), stalls, 3);

        @(negedge clock);
        check($sformatf("%s.idle_after_done", name), busy, 0);
`ifdef SYSCTRL_PERF_EN
        check($sformatf("%s.perf", name), perf_cycles, done_t);
`endif
        if (poke_start) begin
            for (int c = 0; c < 4; c++) begin
                if (busy || mem_rd || arr_ena) bad_idle++;
                @(negedge clock);
            end
            check($sformatf("%s.start_ignored", name), bad_idle, 0);
        end
    endtask

    task automatic illegal(input int kl);
        int n_err = 0;
        int n_act = 0;
        @(negedge clock);
        start = 1'b1;
        k_len = KW'(kl);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            start = 1'b0;
            if (err) n_err++;
            if (busy || mem_rd || arr_ena) n_act++;
        end
        check($sformatf("illegal%0d.err_pulses", kl), n_err, 1);
        check($sformatf("illegal%0d.no_activity", kl), n_act, 0);
    endtask

    task automatic reset_mid_fetch();
        fill_random();
        @(negedge clock);
        start = 1'b1;
        k_len = KW'(4);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_mid.ctrl", {busy, err, done, mem_rd, arr_ena, res_valid, mem_addr, res_row}, 0);
        check("rst_mid.data", |{arr_a_west, arr_b_north, res_data}, 0);
        @(negedge clock);
        check("rst_mid.idle", {busy, mem_rd}, 0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset.ctrl", {busy, err, done, mem_rd, arr_ena, res_valid, mem_addr, res_row}, 0);
        check("reset.data", |{arr_a_west, arr_b_north, res_data}, 0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < N; i++)
            for (int k = 0; k < KMAX; k++) begin
                a_mat[i][k] = (i == k) ? WIDTH'(1) : WIDTH'(0);
                b_mat[k][i] = WIDTH'(k*4 + i + 1);
            end
        run_job(4, 0, 1'b0, "identity");

        for (int i = 0; i < N; i++) begin
            a_mat[i][0] = WIDTH'(2);
            b_mat[0][i] = WIDTH'(i + 3);
        end
        run_job(1, 0, 1'b0, "kmin");

        fill_random();
        run_job(3, 1, 1'b0, "backpressure");

        illegal(0);
        illegal(KMAX + 1);

        reset_mid_fetch();
        fill_random();
        run_job(2, 0, 1'b0, "after_reset");

        fill_random();
        run_job(5, 0, 1'b1, "start_in_output");

        for (int i = 0; i < N; i++)
            for (int k = 0; k < KMAX; k++) begin
                a_mat[i][k] = 16'h0100;
                b_mat[k][i] = 16'h0100;
            end
        run_job(2, 0, 1'b0, "wrap");

        fill_random();
        run_job(KMAX, 2, 1'b0, "kmax");

        for (int r = 0; r < 5; r++) begin
            fill_random();
            run_job($urandom_range(1, KMAX), 2, 1'b0, $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
